// File: rtl/proc_pkg.sv
// Shared types and constants for the 16-bit processor control path.
// Opcodes, FSM states, ALU selects and IR field positions.
package proc_pkg;

  typedef enum logic [3:0] {
    OP_NOOP  = 4'd0,
    OP_STORE = 4'd1,
    OP_LOAD  = 4'd2,
    OP_ADD   = 4'd3,
    OP_SUB   = 4'd4,
    OP_HALT  = 4'd5
  } opcode_e;

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_NOOP   = 4'd3,
    S_LOAD_A = 4'd4,
    S_LOAD_B = 4'd5,
    S_STORE  = 4'd6,
    S_ADD    = 4'd7,
    S_SUB    = 4'd8,
    S_HALT   = 4'd9
  } state_e;

  localparam logic [2:0] ALU_PASS = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_SUB  = 3'd2;

  localparam int OP_MSB   = 15;
  localparam int OP_LSB   = 12;
  localparam int ADDR_MSB = 11;
  localparam int ADDR_LSB = 4;
  localparam int RA_MSB   = 11;
  localparam int RA_LSB   = 8;
  localparam int RB_MSB   = 7;
  localparam int RB_LSB   = 4;
  localparam int RD_MSB   = 3;
  localparam int RD_LSB   = 0;

endpackage

// File: rtl/control_unit_if.sv
// Bundle between the control unit and the PC/IR/memory/RF/ALU datapath.
// master = control unit, slave = datapath side.
interface control_unit_if;

  logic [15:0] ir;
  logic        pc_clr;
  logic        pc_up;
  logic        ir_ld;
  logic [7:0]  d_addr;
  logic        d_wr;
  logic        rf_s;
  logic [3:0]  rf_w_addr;
  logic        rf_w_en;
  logic [3:0]  rf_ra_addr;
  logic [3:0]  rf_rb_addr;
  logic [2:0]  alu_s0;
  logic [3:0]  state_o;

  modport master (
    input  ir,
    output pc_clr, pc_up, ir_ld,
    output d_addr, d_wr,
    output rf_s, rf_w_addr, rf_w_en,
    output rf_ra_addr, rf_rb_addr,
    output alu_s0, state_o
  );

  modport slave (
    output ir,
    input  pc_clr, pc_up, ir_ld,
    input  d_addr, d_wr,
    input  rf_s, rf_w_addr, rf_w_en,
    input  rf_ra_addr, rf_rb_addr,
    input  alu_s0, state_o
  );

endinterface

// File: rtl/control_unit_instr_fields.sv
// Pure slicing of the instruction word into its operand fields.
// The ADD/SUB destination and the LOAD/STORE register share rd.
module instr_fields
  import proc_pkg::*;
(
  input  logic [15:0] ir_i,
  output logic [3:0]  opcode_o,
  output logic [7:0]  mem_addr_o,
  output logic [3:0]  ra_o,
  output logic [3:0]  rb_o,
  output logic [3:0]  rd_o
);

  assign opcode_o   = ir_i[OP_MSB:OP_LSB];
  assign mem_addr_o = ir_i[ADDR_MSB:ADDR_LSB];
  assign ra_o       = ir_i[RA_MSB:RA_LSB];
  assign rb_o       = ir_i[RB_MSB:RB_LSB];
  assign rd_o       = ir_i[RD_MSB:RD_LSB];

endmodule

// File: rtl/control_unit.sv
// Instruction-sequencing FSM; Moore outputs from state plus IR fields.
// HALT is terminal until reset.
module control_unit
  import proc_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  control_unit_if.master bus
);

  state_e state_q;
  state_e state_d;

  logic [3:0] opcode;
  logic [7:0] mem_addr;
  logic [3:0] ra;
  logic [3:0] rb;
  logic [3:0] rd;

  instr_fields u_fields (
    .ir_i       (bus.ir),
    .opcode_o   (opcode),
    .mem_addr_o (mem_addr),
    .ra_o       (ra),
    .rb_o       (rb),
    .rd_o       (rd)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_INIT:   state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        // Undefined opcodes fall through to NOOP
        case (opcode)
          OP_STORE: state_d = S_STORE;
          OP_LOAD:  state_d = S_LOAD_A;
          OP_ADD:   state_d = S_ADD;
          OP_SUB:   state_d = S_SUB;
          OP_HALT:  state_d = S_HALT;
          default:  state_d = S_NOOP;
        endcase
      end
      S_LOAD_A: state_d = S_LOAD_B;
      S_NOOP,
      S_LOAD_B,
      S_STORE,
      S_ADD,
      S_SUB:    state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_INIT;
    endcase
  end

  always_comb begin
    bus.pc_clr     = 1'b0;
    bus.pc_up      = 1'b0;
    bus.ir_ld      = 1'b0;
    bus.d_addr     = 8'd0;
    bus.d_wr       = 1'b0;
    bus.rf_s       = 1'b0;
    bus.rf_w_addr  = 4'd0;
    bus.rf_w_en    = 1'b0;
    bus.rf_ra_addr = 4'd0;
    bus.rf_rb_addr = 4'd0;
    bus.alu_s0     = ALU_PASS;
    bus.state_o    = state_q;
    unique case (state_q)
      S_INIT: bus.pc_clr = 1'b1;
      S_FETCH: begin
        bus.ir_ld = 1'b1;
        bus.pc_up = 1'b1;
      end
      S_LOAD_A: begin
        bus.d_addr    = mem_addr;
        bus.rf_s      = 1'b1;
        bus.rf_w_addr = rd;
      end
      S_LOAD_B: begin
        bus.d_addr    = mem_addr;
        bus.rf_s      = 1'b1;
        bus.rf_w_addr = rd;
        bus.rf_w_en   = 1'b1;
      end
      S_STORE: begin
        bus.d_addr     = mem_addr;
        bus.rf_ra_addr = rd;
        bus.alu_s0     = ALU_PASS;
        bus.d_wr       = 1'b1;
      end
      S_ADD: begin
        bus.rf_ra_addr = ra;
        bus.rf_rb_addr = rb;
        bus.rf_w_addr  = rd;
        bus.alu_s0     = ALU_ADD;
        bus.rf_w_en    = 1'b1;
      end
      S_SUB: begin
        bus.rf_ra_addr = ra;
        bus.rf_rb_addr = rb;
        bus.rf_w_addr  = rd;
        bus.alu_s0     = ALU_SUB;
        bus.rf_w_en    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
